dmem_arbiter: RTL and testbench

- Two-requester arbiter sharing the single 256-bit data-memory port between the instruction cache (port 0) and the data cache (port 1).
- Sits between both cache controllers' memory interfaces and the data memory.
- Grants one whole transaction (enable…ack) at a time with round-robin priority.
- Forces a one-cycle idle gap between transactions and flags memory hangs with a watchdog.

---
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 tb/tb_dmem_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the instruction cache (port 0)
// and the data cache (port 1). It grants one whole transaction at a time, inserts an idle gap after each, and has a hang watchdog.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 256,
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic              p0_ack_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic              p1_ack_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] WAIT_SAT  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             last_grant, last_grant_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             timeout_nxt;
  logic             in_grant;
  logic             cur_enable;
  logic             cur_id;

  // Read data is broadcast to both requesters without registering.
  assign rd_data_o = mem_data_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      wait_cnt   <= '0;
      timeout_o  <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      wait_cnt   <= wait_cnt_nxt;
      timeout_o  <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    wait_cnt_nxt   = wait_cnt;
    timeout_nxt    = timeout_o;
    mem_enable_o   = 1'b0;
    mem_write_o    = 1'b0;
    mem_addr_o     = '0;
    mem_data_o     = '0;
    p0_ack_o       = 1'b0;
    p1_ack_o       = 1'b0;
    busy_o         = 1'b0;
    in_grant       = 1'b0;
    cur_enable     = 1'b0;
    cur_id         = 1'b0;

    case (state)
      IDLE: begin
        // On a tie the port not served last wins; a spurious mem_ack_i is ignored here.
        if (p0_enable_i && p1_enable_i) begin
          state_nxt = last_grant ? GRANT0 : GRANT1;
        end else if (p0_enable_i) begin
          state_nxt = GRANT0;
        end else if (p1_enable_i) begin
          state_nxt = GRANT1;
        end
      end
      GRANT0: begin
        mem_enable_o = p0_enable_i;
        mem_write_o  = p0_write_i;
        mem_addr_o   = p0_addr_i;
        mem_data_o   = p0_data_i;
        p0_ack_o     = mem_ack_i;
        busy_o       = 1'b1;
        in_grant     = 1'b1;
        cur_enable   = p0_enable_i;
        cur_id       = 1'b0;
      end
      GRANT1: begin
        mem_enable_o = p1_enable_i;
        mem_write_o  = p1_write_i;
        mem_addr_o   = p1_addr_i;
        mem_data_o   = p1_data_i;
        p1_ack_o     = mem_ack_i;
        busy_o       = 1'b1;
        in_grant     = 1'b1;
        cur_enable   = p1_enable_i;
        cur_id       = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    // Completion or abort ends the grant; otherwise keep waiting and watch for a hang.
    if (in_grant) begin
      if (wait_cnt == WAIT_LAST && !mem_ack_i) begin
        timeout_nxt = 1'b1;
      end
      if (mem_ack_i || !cur_enable) begin
        state_nxt      = IDLE;
        last_grant_nxt = cur_id;
        wait_cnt_nxt   = '0;
      end else if (wait_cnt != WAIT_SAT) begin
        wait_cnt_nxt = wait_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, watchdog and reset sequences,
// then randomized traffic against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 256;
  localparam int unsigned MAX_WAIT = 8;

  logic              clk;
  logic              rst;
  logic              e0, w0, e1, w1, mack;
  logic [ADDR_W-1:0] a0, a1;
  logic [DATA_W-1:0] d0, d1, mdata_in;
  logic              ack0, ack1, men, mwr, busy, tmo;
  logic [ADDR_W-1:0] maddr;
  logic [DATA_W-1:0] mdata_out, rdata;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk), .rst_i(rst),
    .p0_enable_i(e0), .p0_write_i(w0), .p0_addr_i(a0), .p0_data_i(d0), .p0_ack_o(ack0),
    .p1_enable_i(e1), .p1_write_i(w1), .p1_addr_i(a1), .p1_data_i(d1), .p1_ack_o(ack1),
    .mem_data_i(mdata_in), .mem_ack_i(mack),
    .mem_enable_o(men), .mem_write_o(mwr), .mem_addr_o(maddr), .mem_data_o(mdata_out),
    .rd_data_o(rdata), .busy_o(busy), .timeout_o(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    bit          rst;
    bit          e0, w0;
    logic [31:0] a0;
    bit          e1, w1;
    logic [31:0] a1;
    bit          mack;
    bit          men, mwr;
    logic [31:0] maddr;
    int          sel;   // 0 none, 1 port 0 data, 2 port 1 data on mem_data_o
    bit          ack0, ack1, busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit chk, bit r, bit pe0, bit pw0, logic [31:0] pa0,
                              bit pe1, bit pw1, logic [31:0] pa1, bit ma,
                              bit xmen, bit xmwr, logic [31:0] xaddr, int xsel,
                              bit xack0, bit xack1, bit xbusy);
    vec_t v;
    v.chk = chk; v.rst = r; v.e0 = pe0; v.w0 = pw0; v.a0 = pa0;
    v.e1 = pe1; v.w1 = pw1; v.a1 = pa1; v.mack = ma;
    v.men = xmen; v.mwr = xmwr; v.maddr = xaddr; v.sel = xsel;
    v.ack0 = xack0; v.ack1 = xack1; v.busy = xbusy;
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] rnd_line();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input bit xmen, input bit xmwr, input logic [31:0] xaddr,
                           input logic [DATA_W-1:0] xdata, input bit xack0, input bit xack1,
                           input bit xbusy, input bit xtmo);
    chk({tag, "_men"}, DATA_W'(men), DATA_W'(xmen));
    chk({tag, "_mwr"}, DATA_W'(mwr), DATA_W'(xmwr));
    chk({tag, "_maddr"}, DATA_W'(maddr), DATA_W'(xaddr));
    chk({tag, "_mdata"}, mdata_out, xdata);
    chk({tag, "_ack0"}, DATA_W'(ack0), DATA_W'(xack0));
    chk({tag, "_ack1"}, DATA_W'(ack1), DATA_W'(xack1));
    chk({tag, "_busy"}, DATA_W'(busy), DATA_W'(xbusy));
    chk({tag, "_tmo"}, DATA_W'(tmo), DATA_W'(xtmo));
    chk({tag, "_rdata"}, rdata, mdata_in);
  endtask

  // Transaction-level reference: who owns the memory, who wins the next tie, how long it has waited.
  int owner;       // -1 idle, 0 or 1 = port holding the memory
  bit favor0;
  int waited;
  bit flagged;

  task automatic model_step();
    bit own_en;
    if (rst) begin
      owner = -1; favor0 = 1'b1; waited = 0; flagged = 1'b0;
    end else if (owner < 0) begin
      if (e0 && e1) owner = favor0 ? 0 : 1;
      else if (e0) owner = 0;
      else if (e1) owner = 1;
    end else begin
      own_en = (owner == 0) ? e0 : e1;
      if (waited == int'(MAX_WAIT) - 1 && !mack) flagged = 1'b1;
      if (mack || !own_en) begin
        favor0 = (owner == 1);
        owner  = -1;
        waited = 0;
      end else if (waited < 65535) begin
        waited++;
      end
    end
  endtask

  initial begin
    logic [DATA_W-1:0] xdata;
    rst = 1'b1; e0 = 0; w0 = 0; a0 = '0; e1 = 0; w1 = 0; a1 = '0; mack = 0;
    d0 = rnd_line(); d1 = rnd_line(); mdata_in = '0;

    //            chk r  e0 w0 a0      e1 w1 a1     mk  men mwr addr   sel a0 a1 busy
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,   0, 0, 32'h0,  0,  0, 0, 32'h0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,   0, 0, 32'h0,  0,  0, 0, 32'h0,   0, 0, 0, 0));
    // simultaneous requests after reset: port 0 first, one gap cycle, then port 1
    vecs.push_back(mk(1, 0, 1, 0, 32'h100, 1, 1, 32'h200, 0, 0, 0, 32'h0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h100, 1, 1, 32'h200, 0, 1, 0, 32'h100, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 32'h100, 1, 1, 32'h200, 1, 1, 0, 32'h100, 1, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 32'h100, 1, 1, 32'h200, 0, 0, 0, 32'h0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h100, 1, 1, 32'h200, 1, 1, 1, 32'h200, 2, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,   0, 0, 32'h0,  0,  0, 0, 32'h0,   0, 0, 0, 0));
    // port 1 writeback, port 0, then port 1 refill
    vecs.push_back(mk(1, 0, 0, 0, 32'h300, 1, 1, 32'hA0, 0,  0, 0, 32'h0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h300, 1, 1, 32'hA0, 0,  1, 1, 32'hA0,  2, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 32'h300, 1, 1, 32'hA0, 1,  1, 1, 32'hA0,  2, 0, 1, 1));
    vecs.push_back(mk(1, 0, 1, 0, 32'h300, 1, 0, 32'h40, 0,  0, 0, 32'h0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h300, 1, 0, 32'h40, 0,  1, 0, 32'h300, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 32'h300, 1, 0, 32'h40, 1,  1, 0, 32'h300, 1, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 32'h300, 1, 0, 32'h40, 0,  0, 0, 32'h0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h300, 1, 0, 32'h40, 1,  1, 0, 32'h40,  2, 0, 1, 1));
    // spurious ack in idle, then port 0 abort, then port 1 wins the tie
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,   0, 0, 32'h0,  1,  0, 0, 32'h0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h500, 0, 0, 32'h0,  0,  0, 0, 32'h0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h500, 0, 0, 32'h0,  0,  1, 0, 32'h500, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 32'h500, 1, 0, 32'h600, 0, 0, 0, 32'h500, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 32'h500, 1, 0, 32'h600, 0, 0, 0, 32'h0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h500, 1, 0, 32'h600, 0, 1, 0, 32'h600, 2, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 32'h500, 1, 0, 32'h600, 1, 1, 0, 32'h600, 2, 0, 1, 1));
    // reset mid-GRANT1, then the next tie goes to port 0
    vecs.push_back(mk(1, 0, 0, 0, 32'h500, 1, 0, 32'h600, 0, 0, 0, 32'h0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h500, 1, 0, 32'h600, 0, 1, 0, 32'h600, 2, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 32'h500, 1, 0, 32'h600, 0, 0, 0, 32'h0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h500, 1, 0, 32'h600, 0, 1, 0, 32'h500, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 32'h500, 1, 0, 32'h600, 1, 1, 0, 32'h500, 1, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,   0, 0, 32'h0,  0,  0, 0, 32'h0,   0, 0, 0, 0));

    tick();
    foreach (vecs[i]) begin
      rst = vecs[i].rst; e0 = vecs[i].e0; w0 = vecs[i].w0; a0 = vecs[i].a0;
      e1 = vecs[i].e1; w1 = vecs[i].w1; a1 = vecs[i].a1; mack = vecs[i].mack;
      mdata_in = rnd_line();
      #2;
      if (vecs[i].chk) begin
        xdata = (vecs[i].sel == 1) ? d0 : (vecs[i].sel == 2) ? d1 : '0;
        check_all($sformatf("v%0d", i), vecs[i].men, vecs[i].mwr, vecs[i].maddr, xdata,
                  vecs[i].ack0, vecs[i].ack1, vecs[i].busy, 1'b0);
      end
      tick();
    end

    // Watchdog: memory never acks, flag appears after MAX_WAIT grant cycles, grant held.
    rst = 1'b1; e0 = 0; e1 = 0; mack = 0;
    tick();
    rst = 1'b0; e0 = 1'b1; w0 = 1'b0; a0 = 32'h700;
    #2;
    check_all("wd_idle", 0, 0, 32'h0, '0, 0, 0, 0, 0);
    tick();
    for (int k = 1; k <= 12; k++) begin
      #2;
      check_all($sformatf("wd_g%0d", k), 1, 0, 32'h700, d0, 0, 0, 1, k > int'(MAX_WAIT));
      tick();
    end
    mack = 1'b1;
    #2;
    check_all("wd_lateack", 1, 0, 32'h700, d0, 1, 0, 1, 1);
    tick();
    mack = 1'b0; e0 = 1'b0;
    #2;
    check_all("wd_sticky", 0, 0, 32'h0, '0, 0, 0, 0, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    check_all("wd_cleared", 0, 0, 32'h0, '0, 0, 0, 0, 0);
    tick();

    // Randomized traffic against the reference model.
    owner = -1; favor0 = 1'b1; waited = 0; flagged = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 99) == 0);
      e0   = ($urandom_range(0, 3) != 0);
      e1   = ($urandom_range(0, 3) != 0);
      w0   = $urandom_range(0, 1) == 1;
      w1   = $urandom_range(0, 1) == 1;
      mack = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) begin a0 = $urandom; d0 = rnd_line(); end
      if ($urandom_range(0, 3) == 0) begin a1 = $urandom; d1 = rnd_line(); end
      mdata_in = rnd_line();
      #2;
      if (owner == 0)
        check_all($sformatf("r%0d", c), e0, w0, a0, d0, mack, 0, 1, flagged);
      else if (owner == 1)
        check_all($sformatf("r%0d", c), e1, w1, a1, d1, 0, mack, 1, flagged);
      else
        check_all($sformatf("r%0d", c), 0, 0, 32'h0, '0, 0, 0, 0, flagged);
      model_step();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
